rom_burst_reader: RTL and testbench

//  Read sequencer that sits directly upstream of the 4x16 rom block. Takes a burst request (base, len),

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_rd_fifo.sv | 53 +++++
 rtl/rom_burst_reader.sv | 165 ++++++++++++++++
 tb/tb_rom_burst_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM burst reader: default widths, FSM encoding and ROM read latency.
package rom_pkg;

  localparam int unsigned DEF_ADDR_W  = 4;
  localparam int unsigned DEF_DATA_W  = 4;
  localparam int unsigned ROM_LATENCY = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous FIFO with push/pop/count/full/empty and asynchronous active-high reset.
module rom_rd_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst read sequencer for the registered 4x16 ROM, streaming words out through a credit-managed FIFO.
// Optional ROM_READ_CHECKSUM_EN adds an XOR checksum of the words transferred in the current burst.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              rd,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready
`ifdef ROM_READ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned IF_W  = $clog2(ROM_LATENCY + 1);

  state_e            state_q, state_d;
  logic              cs_q, cs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_q, next_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              len0_done_q, len0_done_d;
  logic [ROM_LATENCY-1:0] vld_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic [IF_W-1:0]   inflight;
  logic [OCC_W-1:0]  occupancy;
  logic              credit, issue, drain_done, start_acc;

  // vld_q[i] marks a read issued i+1 edges ago; the last stage lines up with valid rom_data.
  assign push = vld_q[ROM_LATENCY-1];
  assign pop  = data_valid && data_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(ROM_LATENCY); i++) begin
      inflight = inflight + IF_W'(vld_q[i]);
    end
  end

  // Reserve a FIFO slot for every read still travelling through the ROM pipeline.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign credit    = occupancy < OCC_W'(FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    cs_d        = 1'b0;
    addr_d      = addr_q;
    next_d      = next_q;
    rem_d       = rem_q;
    len0_done_d = 1'b0;
    issue       = 1'b0;
    drain_done  = 1'b0;
    start_acc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_acc = 1'b1;
          if (len != '0) begin
            state_d = StRead;
            next_d  = base;
            rem_d   = len;
          end else begin
            len0_done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (credit) begin
          issue  = 1'b1;
          cs_d   = 1'b1;
          addr_d = next_q;
          next_d = next_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W + 1)'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (inflight == '0 && fifo_count == CNT_W'(1) && pop) begin
          drain_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      next_q      <= '0;
      rem_q       <= '0;
      len0_done_q <= 1'b0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      next_q      <= next_d;
      rem_q       <= rem_d;
      len0_done_q <= len0_done_d;
      vld_q       <= {vld_q[ROM_LATENCY-2:0], issue};
    end
  end

  rom_rd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (rom_data),
    .pop   (pop),
    .rdata (data_out),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cs         = cs_q;
  assign rd         = cs_q;
  assign address    = addr_q;
  assign busy       = (state_q != StIdle);
  assign done       = len0_done_q || drain_done;
  assign data_valid = !fifo_empty;

`ifdef ROM_READ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start_acc) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ data_out;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader with a registered ROM model (rom[a] = ~a) and scoreboard.
module tb_rom_burst_reader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, cs, rd, data_valid;
  logic          data_ready = 1'b0;
  logic [AW-1:0] address;
  logic [DW-1:0] rom_data, data_out;
`ifdef ROM_READ_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  rom_burst_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .cs         (cs),
    .rd         (rd),
    .address    (address),
    .rom_data   (rom_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready)
`ifdef ROM_READ_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Registered ROM: drives X when not selected.
  always @(posedge clk) begin
    if (cs && rd) rom_data <= ~address;
    else          rom_data <= 'x;
  end

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int gap_cnt = 0;
  int ready_mode = 0;
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_addr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0: always ready, 1: ready one cycle in three, 2: random, 3: never ready
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = (cyc % 3 == 0);
        2:       data_ready = 1'($urandom_range(0, 1));
        default: data_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (rd !== cs) check("rd_eq_cs", rd, cs);
      if (cs) begin
        if (exp_addr.size() == 0) check("spurious_cs", cs, 1'b0);
        else                      check("address", address, exp_addr.pop_front());
      end else if (busy && exp_addr.size() > 0) begin
        gap_cnt++;
      end
      if (data_valid && data_ready) begin
        if (exp_data.size() == 0) check("spurious_word", data_valid, 1'b0);
        else                      check("data", data_out, exp_data.pop_front());
        pop_cnt++;
      end
    end
  end

  task automatic push_expect(input logic [AW-1:0] b, input int l);
    for (int i = 0; i < l; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back(~a);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode,
                           input bit lat_chk, input bit intrude);
    int  d0;
    int  k;
    bit  seen;
    push_expect(b, int'(l));
    ready_mode = mode;
    d0 = done_cnt;
    gap_cnt = 0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = b;
    len   = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    base  = AW'($urandom);
    len   = (AW + 1)'($urandom);
    for (k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (intrude && k == 2) begin
        start = 1'b1;
        base  = 4'd9;
        len   = 5'd2;
      end
      if (intrude && k == 3) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1'b1);
    if (lat_chk) check("latency", k, (l == 0) ? 1 : int'(l) + 3);
    repeat (3) @(negedge clk);
    check("busy_after", busy, 1'b0);
    check("done_pulses", done_cnt - d0, 1);
    check("words_left", exp_data.size(), 0);
    check("issues_left", exp_addr.size(), 0);
    if (mode == 1) check("cs_throttled", gap_cnt > 0, 1'b1);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;
    bit            lat_chk;
    bit            intrude;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0;
    int d0;
    bit got;
    vecs[0] = '{4'd2,  5'd3,  0, 1'b1, 1'b0};
    vecs[1] = '{4'd14, 5'd4,  0, 1'b1, 1'b0};
    vecs[2] = '{4'd0,  5'd16, 1, 1'b0, 1'b0};
    vecs[3] = '{4'd0,  5'd0,  0, 1'b1, 1'b0};
    vecs[4] = '{4'd3,  5'd5,  2, 1'b0, 1'b1};
    vecs[5] = '{4'd15, 5'd5,  0, 1'b1, 1'b1};
    vecs[6] = '{4'd7,  5'd1,  0, 1'b1, 1'b0};
    vecs[7] = '{4'd9,  5'd16, 2, 1'b0, 1'b0};

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cs", cs, 1'b0);
    check("rst_rd", rd, 1'b0);
    check("rst_address", address, '0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_data", data_out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].lat_chk, vecs[i].intrude);
    end

    // Asynchronous reset after two words of an 8-word burst.
    push_expect(4'd0, 8);
    ready_mode = 0;
    p0 = pop_cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 4'd0;
    len   = 5'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pop_cnt >= p0 + 2) begin
        got = 1'b1;
        break;
      end
    end
    check("two_words_before_rst", got, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_cs", cs, 1'b0);
    check("rst_mid_valid", data_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    exp_data.delete();
    exp_addr.delete();
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_rst", done_cnt, d0);
    check("idle_after_rst", busy, 1'b0);
    run_burst(4'd5, 5'd2, 0, 1'b1, 1'b0);

`ifdef ROM_READ_CHECKSUM_EN
    run_burst(4'd2, 5'd3, 0, 1'b1, 1'b0);
    check("checksum_dcb", checksum, 4'hA);
    run_burst(4'd0, 5'd4, 0, 1'b1, 1'b0);
    check("checksum_fedc", checksum, 4'h0);
    run_burst(4'd2, 5'd3, 0, 1'b1, 1'b0);
    check("checksum_hold", checksum, 4'hA);
    push_expect(4'd5, 2);
    ready_mode = 3;
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 4'd5;
    len   = 5'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("checksum_cleared", checksum, 4'h0);
    ready_mode = 0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    check("checksum_burst_end", got, 1'b1);
    check("checksum_a9", checksum, 4'h3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
